// File: rtl/aes_key_expand_seq.sv
// Sequential AES-128 key schedule: emits round keys 0..10, one per pulse,
// deriving each from the previous via four registered S-box lookups.

module sub_bytes_freq (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] dout
);

  localparam logic [7:0] INV_EXP = 8'hfe;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as the GF(2^8) inverse (x^254, which maps 0 to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] sq;
    inv = 8'h01;
    sq  = x;
    for (int i = 0; i < 8; i++) begin
      if (INV_EXP[i]) inv = gf_mul(inv, sq);
      sq = gf_mul(sq, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      dout <= 8'h00;
    end else if (en) begin
      dout <= sbox(din);
    end
  end

endmodule

module aes_key_expand_seq (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 start,
  input  logic [3:0][3:0][7:0] key_in,
  output logic [3:0][3:0][7:0] round_key,
  output logic [3:0]           rk_round,
  output logic                 rk_valid,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {IDLE, SUB, GEN} state_t;

  state_t               state_reg;
  logic [3:0][3:0][7:0] key_reg;
  logic [3:0]           rnd_reg;
  logic [7:0]           rcon_reg;

  logic [31:0] rot_word;
  logic [31:0] sbox_word;
  logic [31:0] w0_next, w1_next, w2_next, w3_next;
  logic [127:0] key_next;

  // RotWord of w3: bytes {b1,b2,b3,b0}, b0 being the most significant byte.
  assign rot_word = {key_reg[0][2], key_reg[0][1], key_reg[0][0], key_reg[0][3]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      sub_bytes_freq u_sbox (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .din  (rot_word[gi*8 +: 8]),
        .dout (sbox_word[gi*8 +: 8])
      );
    end
  endgenerate

  assign w0_next  = key_reg[3] ^ sbox_word ^ {rcon_reg, 24'h000000};
  assign w1_next  = key_reg[2] ^ w0_next;
  assign w2_next  = key_reg[1] ^ w1_next;
  assign w3_next  = key_reg[0] ^ w2_next;
  assign key_next = {w0_next, w1_next, w2_next, w3_next};

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      key_reg   <= '0;
      rnd_reg   <= 4'd0;
      rcon_reg  <= 8'h00;
      round_key <= '0;
      rk_round  <= 4'd0;
      rk_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (en) begin
      rk_valid <= 1'b0;
      done     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            key_reg   <= key_in;
            round_key <= key_in;
            rk_round  <= 4'd0;
            rk_valid  <= 1'b1;
            rnd_reg   <= 4'd1;
            rcon_reg  <= 8'h01;
            busy      <= 1'b1;
            state_reg <= SUB;
          end
        end
        SUB: begin
          state_reg <= GEN;
        end
        GEN: begin
          key_reg   <= key_next;
          round_key <= key_next;
          rk_round  <= rnd_reg;
          rk_valid  <= 1'b1;
          if (rnd_reg == 4'd10) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else begin
            rnd_reg   <= rnd_reg + 4'd1;
            rcon_reg  <= xtime(rcon_reg);
            state_reg <= SUB;
          end
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
